// File: rtl/fifo_pkg.sv
// Vector FIFO constants and the read-controller state encoding.
package fifo_pkg;
    localparam int COUNT_N = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RDY,
        READ,
        DRAIN
    } reader_state_t;
endpackage

// File: rtl/global_pkg.sv
// Project-wide data types shared by the vector FIFO and its neighbours.
package global_pkg;
    typedef logic [7:0] data_t;
    typedef logic [3:0] nibble_t;
endpackage

// File: rtl/fifo_vector_reader_skid.sv
// Two-entry skid buffer (reader_skid): absorbs the FIFO read latency and
// presents the head element as a valid/ready stream.
module reader_skid
    import global_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  data_t       data_i,
    output data_t       data_o,
    output logic        valid_o,
    output logic [1:0]  occ_o
);
    data_t      head_q, head_d;
    data_t      tail_q, tail_d;
    logic [1:0] occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q + {1'b0, push_i} - {1'b0, pop_i};
        if (pop_i) begin
            if (occ_q == 2'd2) begin
                head_d = tail_q;
                if (push_i) tail_d = data_i;
            end else if (push_i) begin
                head_d = data_i;
            end
        end else if (push_i) begin
            // Upstream credit guarantees no push arrives while both entries are held.
            if (occ_q == 2'd0) head_d = data_i;
            else               tail_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = (occ_q != 2'd0);
    assign occ_o   = occ_q;
endmodule

// File: rtl/fifo_vector_reader.sv
// Read-side controller for the vector FIFO: pops N elements per start and streams them out.
// Optional sticky underflow checker enabled by defining FIFO_READER_UNDERFLOW_CHK_EN.
module fifo_vector_reader
    import global_pkg::*;
    import fifo_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  nibble_t N,
    input  logic    fifo_ready,
    input  data_t   fifo_data,
    output logic    fifo_pop,
    output data_t   out_data,
    output logic    out_valid,
    output logic    out_last,
    input  logic    out_ready,
    output logic    busy,
    output logic    done,
    output logic    underflow
);
    reader_state_t      state_q;
    nibble_t            n_q;
    nibble_t            rem_q;
    logic [COUNT_N-1:0] out_cnt_q;
    logic               inflight_q;
    logic               done_q;
    logic [1:0]         occ;
    logic               deq;
    logic [2:0]         level;
    logic [2:0]         occ_next;

    reader_skid u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (inflight_q),
        .pop_i   (deq),
        .data_i  (fifo_data),
        .data_o  (out_data),
        .valid_o (out_valid),
        .occ_o   (occ)
    );

    // Credit counts the element already in flight so the skid can never overflow.
    always_comb begin
        deq      = out_valid & out_ready;
        level    = 3'(inflight_q) + 3'(occ) - 3'(deq);
        occ_next = 3'(occ) + 3'(inflight_q) - 3'(deq);
        fifo_pop = (state_q == READ) && (rem_q != '0) && (level < 3'd2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            rem_q      <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= fifo_pop;
            done_q     <= 1'b0;
            if (deq) out_cnt_q <= out_cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        out_cnt_q <= '0;
                        if (N == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            n_q     <= N;
                            rem_q   <= N;
                            state_q <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (fifo_ready) state_q <= READ;
                end
                READ: begin
                    if (fifo_pop) begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == nibble_t'(1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave one cycle early so done lines up with the last element leaving.
                    if (occ_next == 3'd0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign out_last = out_valid && (out_cnt_q == COUNT_N'(n_q - 1'b1));

`ifdef FIFO_READER_UNDERFLOW_CHK_EN
    logic underflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow_q <= 1'b0;
        end else if ((state_q == READ) && (rem_q != '0) && !fifo_ready) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_vector_reader.sv
// Directed bench for fifo_vector_reader: cycle table for the basic read plus multi-cycle sequences.
module tb_fifo_vector_reader;
    import global_pkg::*;

`ifdef FIFO_READER_UNDERFLOW_CHK_EN
    localparam logic UF_EXP = 1'b1;
`else
    localparam logic UF_EXP = 1'b0;
`endif

    logic    clk = 1'b0;
    logic    rst;
    logic    start;
    nibble_t n_in;
    logic    fifo_ready;
    data_t   fifo_data = '0;
    logic    fifo_pop;
    data_t   out_data;
    logic    out_valid;
    logic    out_last;
    logic    out_ready;
    logic    busy;
    logic    done;
    logic    underflow;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    data_t fq[$];
    data_t exp_q[$];

    typedef struct {
        logic    start;
        nibble_t n;
        logic    fr;
        logic    ordy;
        logic    pop;
        logic    vld;
        data_t   dat;
        logic    last;
        logic    busy;
        logic    done;
    } vec_t;
    vec_t tbl[10];

    fifo_vector_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .N          (n_in),
        .fifo_ready (fifo_ready),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // FIFO model: data_out is registered, valid the cycle after pop.
    always @(posedge clk) begin
        if (fifo_pop) begin
            pops <= pops + 1;
            if (fq.size() > 0) fifo_data <= fq.pop_front();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pop"},  32'(fifo_pop),  32'd0);
        chk({tag, "_vld"},  32'(out_valid), 32'd0);
        chk({tag, "_last"}, 32'(out_last),  32'd0);
        chk({tag, "_data"}, 32'(out_data),  32'd0);
        chk({tag, "_busy"}, 32'(busy),      32'd0);
        chk({tag, "_done"}, 32'(done),      32'd0);
        chk({tag, "_uf"},   32'(underflow), 32'd0);
    endtask

    // One vector read from start to done; exp_q holds the expected element order.
    task automatic run_read(input string tag, input nibble_t n, input int mode, input int frd,
                            input int glitch_k, input int drop_k, input int budget);
        int    pb, acc, first_pop, outstanding;
        logic  prev_stall, seen_done;
        data_t prev_d;
        pb = pops; acc = 0; first_pop = -1; prev_stall = 1'b0; seen_done = 1'b0; prev_d = '0;
        cyc();
        start = 1'b1; n_in = n; fifo_ready = (0 > frd); out_ready = (mode == 0);
        #1;
        for (int k = 1; k < budget && !seen_done; k++) begin
            cyc();
            start      = (k == glitch_k);
            fifo_ready = (k > frd) && (k != drop_k);
            out_ready  = (mode == 0) ? 1'b1 : (k % 2 == 1);
            #1;
            if (k <= frd) begin
                chk({tag, "_wait_busy"}, 32'(busy), 32'd1);
                chk({tag, "_wait_pop"},  32'(fifo_pop), 32'd0);
            end
            if (fifo_pop) begin
                if (first_pop < 0) first_pop = k;
                outstanding = (pops - pb) - acc - int'(out_valid & out_ready);
                chk({tag, "_credit"}, 32'(outstanding < 2), 32'd1);
            end
            if (prev_stall) begin
                chk({tag, "_stall_vld"},  32'(out_valid), 32'd1);
                chk({tag, "_stall_data"}, 32'(out_data),  32'(prev_d));
            end
            if (out_valid && out_ready) begin
                if (acc < exp_q.size()) chk({tag, "_data"}, 32'(out_data), 32'(exp_q[acc]));
                else                    chk({tag, "_extra"}, 32'(acc), 32'(exp_q.size()));
                chk({tag, "_last"}, 32'(out_last), 32'(acc == int'(n) - 1));
                acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            if (done) begin
                seen_done = 1'b1;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                if (mode == 0) chk({tag, "_done_cycle"}, 32'(k), 32'(int'(n) + 4 + frd));
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_first_pop"}, 32'(first_pop), 32'(frd + 2));
        chk({tag, "_pops"},      32'(pops - pb), 32'(n));
        chk({tag, "_accepted"},  32'(acc),       32'(n));
    endtask

    initial begin
        //             start n     fr    ordy  pop   vld   dat    last  busy  done
        tbl[0] = '{1'b1, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        rst = 1'b0; start = 1'b0; n_in = '0; fifo_ready = 1'b0; out_ready = 1'b0;
        fq.delete();
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
        cyc(); #1;
        chk_reset_outputs("reset");
        cyc(); rst = 1'b1; #1;

        for (int i = 0; i < 10; i++) begin
            cyc();
            start = tbl[i].start; n_in = tbl[i].n; fifo_ready = tbl[i].fr; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_pop", i),  32'(fifo_pop),  32'(tbl[i].pop));
            chk($sformatf("tbl%0d_vld", i),  32'(out_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].dat));
            chk($sformatf("tbl%0d_last", i), 32'(out_last),  32'(tbl[i].last));
            chk($sformatf("tbl%0d_busy", i), 32'(busy),      32'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), 32'(done),      32'(tbl[i].done));
        end

        // Backpressure: out_ready toggles every cycle.
        fq.delete(); exp_q.delete();
        foreach (tbl[i]) if (i < 4) begin
            fq.push_back(data_t'(8'hA1 + i)); exp_q.push_back(data_t'(8'hA1 + i));
        end
        run_read("alt", 4'd4, 1, 0, -1, -1, 40);

        // fifo_ready held low for five cycles after start.
        fq.delete(); exp_q.delete();
        fq.push_back(8'hB1); fq.push_back(8'hB2);
        exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
        run_read("wait", 4'd2, 0, 5, -1, -1, 40);

        // N=0 start completes immediately without touching the FIFO.
        begin
            int pb;
            pb = pops;
            cyc(); start = 1'b1; n_in = 4'd0; #1;
            cyc(); start = 1'b0; #1;
            chk("n0_done", 32'(done), 32'd1);
            chk("n0_busy", 32'(busy), 32'd0);
            chk("n0_pop",  32'(fifo_pop), 32'd0);
            cyc(); #1;
            chk("n0_done_clr", 32'(done), 32'd0);
            chk("n0_pops", 32'(pops - pb), 32'd0);
        end

        // start pulse during an N=3 read must be ignored.
        fq.delete(); exp_q.delete();
        fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3); fq.push_back(8'hC4);
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        run_read("glitch", 4'd3, 0, 0, 3, -1, 30);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("glitch_idle_busy", 32'(busy), 32'd0);
            chk("glitch_idle_pop",  32'(fifo_pop), 32'd0);
        end

        // Reset after two of five pops, then a fresh N=2 read.
        fq.delete();
        for (int i = 0; i < 5; i++) fq.push_back(data_t'(8'h51 + i));
        begin
            int pb;
            pb = pops;
            cyc(); start = 1'b1; n_in = 4'd5; fifo_ready = 1'b1; out_ready = 1'b1; #1;
            cyc(); start = 1'b0; #1;
            cyc(); #1;
            cyc(); #1;
            cyc(); #1;
            chk("rstmid_pops", 32'(pops - pb), 32'd2);
            rst = 1'b0;
            #1;
            chk_reset_outputs("rstmid");
            cyc(); rst = 1'b1; #1;
        end
        exp_q.delete();
        exp_q.push_back(8'h53); exp_q.push_back(8'h54);
        run_read("postrst", 4'd2, 0, 0, -1, -1, 30);

        // fifo_ready dropped during READ: sticky flag only when the checker is built.
        fq.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            fq.push_back(data_t'(8'hD1 + i)); exp_q.push_back(data_t'(8'hD1 + i));
        end
        run_read("uf", 4'd4, 0, 0, -1, 3, 30);
        chk("uf_flag", 32'(underflow), 32'(UF_EXP));
        cyc(); cyc(); #1;
        chk("uf_sticky", 32'(underflow), 32'(UF_EXP));
        rst = 1'b0;
        #1;
        chk("uf_cleared", 32'(underflow), 32'd0);
        cyc(); rst = 1'b1; #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
